seguidor_linea_pwm: RTL

Parametrised line-follower controller that replaces the fixed two-sensor follower inside `top`. It samples an N-sensor line array, filters it, and steers through a five-state machine. When the line is lost it runs a timed search spin, then stops. Left and right motor speed are driven by internal PWM generators on `ENA`/`ENB`, with direction on `IN1`/`IN3`.

---
 rtl/seguidor_linea_pwm.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/seguidor_linea_pwm.sv
// Line-follower controller: synchronised, debounced N-sensor array steering a
// five-state FSM whose per-state duties drive two glitch-free PWM generators.
module seguidor_linea_pwm #(
  parameter int N_SENS       = 3,
  parameter int PWM_BITS     = 8,
  parameter int SPEED_FWD    = 200,
  parameter int SPEED_TURN   = 120,
  parameter int DEB_CYCLES   = 4,
  parameter int LOST_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SENS-1:0] sensor,
  output logic              ENA,
  output logic              IN1,
  output logic              ENB,
  output logic              IN3,
  output logic [2:0]        state
);

  localparam int CIDX   = N_SENS / 2;
  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int LOST_W = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
  localparam logic [DEB_W-1:0]    DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [LOST_W-1:0]   LOST_LAST = LOST_W'(LOST_TIMEOUT - 1);
  localparam logic [PWM_BITS-1:0] DUTY_FWD  = PWM_BITS'(SPEED_FWD);
  localparam logic [PWM_BITS-1:0] DUTY_TURN = PWM_BITS'(SPEED_TURN);

  if ((N_SENS < 3) || ((N_SENS % 2) == 0)) begin : g_chk_nsens
    $error("seguidor_linea_pwm: N_SENS must be odd and at least 3");
  end
  if (DEB_CYCLES < 1) begin : g_chk_deb
    $error("seguidor_linea_pwm: DEB_CYCLES must be at least 1");
  end
  if (LOST_TIMEOUT < 1) begin : g_chk_lost
    $error("seguidor_linea_pwm: LOST_TIMEOUT must be at least 1");
  end
  if (PWM_BITS < 1) begin : g_chk_pwm
    $error("seguidor_linea_pwm: PWM_BITS must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_FOLLOW = 3'd1,
    ST_TURN_L = 3'd2,
    ST_TURN_R = 3'd3,
    ST_SEARCH = 3'd4
  } state_t;

  logic [N_SENS-1:0]   r_sync_p0, r_sync_p1, r_prev_p2, r_filt;
  logic [DEB_W-1:0]    r_deb, w_deb_nxt;
  logic                w_accept;
  logic                w_c, w_l, w_r, w_center, w_left, w_right;
  state_t              r_state, w_state_nxt;
  logic                r_last_right;
  logic [LOST_W-1:0]   r_lost;
  logic [PWM_BITS-1:0] w_duty_l, w_duty_r, w_duty_l_eff, w_duty_r_eff;
  logic                w_dir_l, w_dir_r, w_load;
  logic [PWM_BITS-1:0] r_cnt, r_duty_l, r_duty_r;
  logic                r_ena, r_enb, r_in1, r_in3;

  // Stage p0/p1: two-flop synchroniser; p2: previous synchronised sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_prev_p2 <= '0;
    end else begin
      r_sync_p0 <= sensor;
      r_sync_p1 <= r_sync_p0;
      r_prev_p2 <= r_sync_p1;
    end
  end

  // The stable count saturates, so a held vector keeps being re-accepted unchanged.
  always_comb begin
    w_deb_nxt = '0;
    if (r_sync_p1 == r_prev_p2) begin
      w_deb_nxt = (r_deb == DEB_LAST) ? r_deb : r_deb + 1'b1;
    end
  end

  assign w_accept = (w_deb_nxt == DEB_LAST);

  // Debounced vector boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb  <= '0;
      r_filt <= '0;
    end else begin
      r_deb <= w_deb_nxt;
      if (w_accept) r_filt <= r_sync_p1;
    end
  end

  assign w_c      = r_filt[CIDX];
  assign w_l      = |r_filt[N_SENS-1:CIDX+1];
  assign w_r      = |r_filt[CIDX-1:0];
  assign w_center = w_c | (w_l & w_r);
  assign w_left   = w_l & ~w_r & ~w_c;
  assign w_right  = w_r & ~w_l & ~w_c;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_STOP;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_center)      w_state_nxt = ST_FOLLOW;
    else if (w_left)   w_state_nxt = ST_TURN_L;
    else if (w_right)  w_state_nxt = ST_TURN_R;
    else begin
      case (r_state)
        ST_FOLLOW, ST_TURN_L, ST_TURN_R: w_state_nxt = ST_SEARCH;
        ST_SEARCH: w_state_nxt = (r_lost == LOST_LAST) ? ST_STOP : ST_SEARCH;
        default:   w_state_nxt = ST_STOP;
      endcase
    end
  end

  // Lost counter only runs while search continues; any other path discards it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_right <= 1'b0;
      r_lost       <= '0;
    end else begin
      if (w_left)       r_last_right <= 1'b0;
      else if (w_right) r_last_right <= 1'b1;
      if ((r_state == ST_SEARCH) && (w_state_nxt == ST_SEARCH)) r_lost <= r_lost + 1'b1;
      else                                                      r_lost <= '0;
    end
  end

  always_comb begin
    w_duty_l = '0;
    w_duty_r = '0;
    w_dir_l  = 1'b1;
    w_dir_r  = 1'b1;
    case (r_state)
      ST_FOLLOW: begin
        w_duty_l = DUTY_FWD;
        w_duty_r = DUTY_FWD;
      end
      ST_TURN_L: begin
        w_duty_l = DUTY_TURN;
        w_duty_r = DUTY_FWD;
      end
      ST_TURN_R: begin
        w_duty_l = DUTY_FWD;
        w_duty_r = DUTY_TURN;
      end
      ST_SEARCH: begin
        w_duty_l = DUTY_TURN;
        w_duty_r = DUTY_TURN;
        if (r_last_right) w_dir_r = 1'b0;
        else              w_dir_l = 1'b0;
      end
      default: ;
    endcase
  end

  // The compare at cnt==0 already uses the duty being loaded, so every
  // period is evaluated against a single duty value.
  assign w_load       = (r_cnt == '0);
  assign w_duty_l_eff = w_load ? w_duty_l : r_duty_l;
  assign w_duty_r_eff = w_load ? w_duty_r : r_duty_r;

  // PWM output register boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_duty_l <= '0;
      r_duty_r <= '0;
      r_ena    <= 1'b0;
      r_enb    <= 1'b0;
      r_in1    <= 1'b1;
      r_in3    <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_load) begin
        r_duty_l <= w_duty_l;
        r_duty_r <= w_duty_r;
        r_in1    <= w_dir_l;
        r_in3    <= w_dir_r;
      end
      r_ena <= (r_cnt < w_duty_l_eff);
      r_enb <= (r_cnt < w_duty_r_eff);
    end
  end

  assign ENA   = r_ena;
  assign ENB   = r_enb;
  assign IN1   = r_in1;
  assign IN3   = r_in3;
  assign state = r_state;

endmodule
